// File: rtl/control_filtropa20.sv
// ---------------------------------------------------------------------------
// control_filtropa20
//
// Purpose:
//   Sequencer for the 20 Hz high-pass filter datapath (filtropa20). For every
//   accepted sample strobe it runs one shift step followed by five
//   multiply-accumulate steps through the shared arithmetic unit:
//     f(k) = c0*f(k-1) + c1*f(k-2) + u(k)
//     y(k) = c2*f(k)   + c3*f(k-1) + c2*f(k-2)
//   and then pulses done for one cycle when YK holds the new y(k).
//
// Parameters:
//   MAC_WAIT  extra hold cycles per MAC step (0..15). The selects of a MAC
//             step are held for 1+MAC_WAIT cycles and its register enable
//             is raised on the last of those cycles only.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous reset, active low
//   start    in   1  sample strobe, acted upon only in IDLE
//   clr_ovr  in   1  synchronous clear of the overrun flag
//   muxS     out  3  multiplicand select (0=Uk,1=fk,2=fk1,3=fk2,4=yk)
//   muxC     out  2  coefficient select (0=c0,1=c1,2=c2,3=c3)
//   muxZ     out  2  addend select (0=zero,1=yk,2=fk,3=Uk)
//   en1..en4 out  1  register enables for yk, fk, fk1, fk2
//   busy     out  1  high from SHIFT through Y3
//   done     out  1  one-cycle pulse, YK valid
//   ovr      out  1  sticky overrun flag (strobe seen while not idle)
// ---------------------------------------------------------------------------
module control_filtropa20 #(
    parameter int unsigned MAC_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       clr_ovr,
    output logic [2:0] muxS,
    output logic [1:0] muxC,
    output logic [1:0] muxZ,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       busy,
    output logic       done,
    output logic       ovr
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        F1,
        F2,
        Y1,
        Y2,
        Y3,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(MAC_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ovr_q, ovr_d;

    logic [2:0] muxS_q, muxS_d;
    logic [1:0] muxC_q, muxC_d;
    logic [1:0] muxZ_q, muxZ_d;
    logic       en1_q, en1_d;
    logic       en2_q, en2_d;
    logic       en3_q, en3_d;
    logic       en4_q, en4_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       lastCycle;
    logic       macLast;

    // Next-state logic. A MAC step only leaves once its hold counter reaches
    // MAC_WAIT; the counter restarts from zero on entry to every MAC step.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lastCycle = (cnt_q == WAIT_CNT);
        unique case (state_q)
            IDLE:  if (start) state_d = SHIFT;
            SHIFT: begin
                state_d = F1;
                cnt_d   = '0;
            end
            F1, F2, Y1, Y2, Y3: begin
                if (lastCycle) begin
                    cnt_d = '0;
                    unique case (state_q)
                        F1:      state_d = F2;
                        F2:      state_d = Y1;
                        Y1:      state_d = Y2;
                        Y2:      state_d = Y3;
                        default: state_d = DONE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Overrun: a strobe outside IDLE is dropped but remembered. Setting has
    // priority over the clear so a simultaneous clear cannot hide an overrun.
    always_comb begin
        ovr_d = ovr_q;
        if (state_q != IDLE && start) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    // Output decode from the upcoming state/counter, so the registered
    // outputs line up exactly with the state they describe.
    always_comb begin
        muxS_d  = 3'd0;
        muxC_d  = 2'd0;
        muxZ_d  = 2'd0;
        en1_d   = 1'b0;
        en2_d   = 1'b0;
        en3_d   = 1'b0;
        en4_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        macLast = (cnt_d == WAIT_CNT);
        unique case (state_d)
            SHIFT: begin
                en3_d  = 1'b1;
                en4_d  = 1'b1;
                busy_d = 1'b1;
            end
            F1: begin
                muxS_d = 3'd2; muxC_d = 2'd0; muxZ_d = 2'd3;
                en2_d  = macLast;
                busy_d = 1'b1;
            end
            F2: begin
                muxS_d = 3'd3; muxC_d = 2'd1; muxZ_d = 2'd2;
                en2_d  = macLast;
                busy_d = 1'b1;
            end
            Y1: begin
                muxS_d = 3'd1; muxC_d = 2'd2; muxZ_d = 2'd0;
                en1_d  = macLast;
                busy_d = 1'b1;
            end
            Y2: begin
                muxS_d = 3'd2; muxC_d = 2'd3; muxZ_d = 2'd1;
                en1_d  = macLast;
                busy_d = 1'b1;
            end
            Y3: begin
                muxS_d = 3'd3; muxC_d = 2'd2; muxZ_d = 2'd1;
                en1_d  = macLast;
                busy_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // State, hold counter, overrun flag and all outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            muxS_q  <= '0;
            muxC_q  <= '0;
            muxZ_q  <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            en3_q   <= 1'b0;
            en4_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            muxS_q  <= muxS_d;
            muxC_q  <= muxC_d;
            muxZ_q  <= muxZ_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            en3_q   <= en3_d;
            en4_q   <= en4_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign muxS = muxS_q;
    assign muxC = muxC_q;
    assign muxZ = muxZ_q;
    assign en1  = en1_q;
    assign en2  = en2_q;
    assign en3  = en3_q;
    assign en4  = en4_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovr  = ovr_q;

endmodule
